// File: rtl/maj_tt_pkg.sv
// Shared definitions for the majority truth-table sweeper.
// - Operand index encoding: 0 = constant 0, IDX_IN_BASE+i = input x_i,
//   idx_node_base(NUM_IN)+k = majority node k.
// - Node word layout: three operand fields of (OP_W+1) bits each,
//   operand a in the LSBs; each field is {inv, idx}.
// - FSM state encoding.
package maj_tt_pkg;

    localparam int IDX_ZERO    = 0;
    localparam int IDX_IN_BASE = 1;

    // First node index sits directly after the primary inputs.
    function automatic int idx_node_base(input int num_in);
        return IDX_IN_BASE + num_in;
    endfunction

    // LSB of operand field o (0=a, 1=b, 2=c) within a node word.
    function automatic int op_lsb(input int op_w, input int o);
        return o * (op_w + 1);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/maj_net_eval.sv
// Combinational evaluator for a programmable majority network.
// Ports:
//   node_tbl : flattened node table, node k at [k*NODE_W +: NODE_W]
//   minterm  : current input assignment, x_i = minterm[i]
//   node_val : value of every node for this minterm
//   illegal  : some operand references a node >= its own index or an
//              index beyond the table (such operands read as 0)
module maj_net_eval
    import maj_tt_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int NUM_NODES = 8,
    localparam int OP_W     = $clog2(1 + NUM_IN + NUM_NODES),
    localparam int NODE_W   = 3 * (OP_W + 1)
) (
    input  logic [NUM_NODES*NODE_W-1:0] node_tbl,
    input  logic [NUM_IN-1:0]           minterm,
    output logic [NUM_NODES-1:0]        node_val,
    output logic                        illegal
);

    localparam int NODE_BASE = idx_node_base(NUM_IN);

    // Nodes are resolved in index order, so a node may only see values of
    // lower-numbered nodes already computed in this pass.
    always_comb begin
        logic [NUM_NODES-1:0] vals;
        logic [OP_W-1:0]      idx;
        logic [2:0]           ops;
        logic                 v;
        vals    = '0;
        idx     = '0;
        ops     = '0;
        v       = 1'b0;
        illegal = 1'b0;
        for (int k = 0; k < NUM_NODES; k++) begin
            for (int o = 0; o < 3; o++) begin
                idx = node_tbl[k*NODE_W + op_lsb(OP_W, o) +: OP_W];
                v   = 1'b0;
                for (int i = 0; i < NUM_IN; i++) begin
                    if (int'(idx) == IDX_IN_BASE + i) v = minterm[i];
                end
                for (int j = 0; j < NUM_NODES; j++) begin
                    if (int'(idx) == NODE_BASE + j) begin
                        if (j < k) v = vals[j];
                        else       illegal = 1'b1;
                    end
                end
                if (int'(idx) >= NODE_BASE + NUM_NODES) illegal = 1'b1;
                ops[o] = v ^ node_tbl[k*NODE_W + op_lsb(OP_W, o) + OP_W];
            end
            vals[k] = (ops[0] & ops[1]) | (ops[0] & ops[2]) | (ops[1] & ops[2]);
        end
        node_val = vals;
    end

endmodule

// File: rtl/maj_tt_sweeper.sv
// Sweeps all 2^NUM_IN minterms through a run-time loaded majority network,
// building the full truth table and its on-set count.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   cfg_we/addr/data      : node table write (ignored while sweeping)
//   out_node, out_inv     : output node select / invert, latched at start
//   start                 : begin a sweep (only honoured in IDLE)
//   busy                  : sweep in progress
//   cfg_err               : sticky illegal-reference flag for this sweep
//   res_valid, res_ready  : result handshake
//   tt, ones_cnt          : truth table (bit m = f(m)) and its popcount
module maj_tt_sweeper
    import maj_tt_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int NUM_NODES = 8,
    localparam int OP_W     = $clog2(1 + NUM_IN + NUM_NODES),
    localparam int NODE_W   = 3 * (OP_W + 1),
    localparam int AW       = $clog2(NUM_NODES),
    localparam int TT_W     = 1 << NUM_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [NODE_W-1:0] cfg_data,
    input  logic [AW-1:0]     out_node,
    input  logic              out_inv,
    input  logic              start,
    output logic              busy,
    output logic              cfg_err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TT_W-1:0]   tt,
    output logic [NUM_IN:0]   ones_cnt
);

    state_t                              state_q, state_d;
    logic [NUM_NODES-1:0][NODE_W-1:0]    tbl_q, tbl_d;
    logic [NUM_IN-1:0]                   cnt_q, cnt_d;
    logic [TT_W-1:0]                     tt_q, tt_d;
    logic [NUM_IN:0]                     ones_q, ones_d;
    logic                                err_q, err_d;
    logic [AW-1:0]                       out_node_q, out_node_d;
    logic                                out_inv_q, out_inv_d;

    logic [NUM_NODES-1:0]                node_val;
    logic                                illegal;
    logic                                f_bit;
    logic                                start_acc;
    logic                                last_m;

    maj_net_eval #(
        .NUM_IN    (NUM_IN),
        .NUM_NODES (NUM_NODES)
    ) u_eval (
        .node_tbl (tbl_q),
        .minterm  (cnt_q),
        .node_val (node_val),
        .illegal  (illegal)
    );

    assign f_bit     = node_val[out_node_q] ^ out_inv_q;
    assign start_acc = start && (state_q == ST_IDLE);
    assign last_m    = (cnt_q == {NUM_IN{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)     state_d = ST_SWEEP;
            ST_SWEEP: if (last_m)    state_d = ST_DONE;
            ST_DONE:  if (res_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SWEEP);
        res_valid = (state_q == ST_DONE);
    end

    always_comb begin
        tbl_d      = tbl_q;
        cnt_d      = cnt_q;
        tt_d       = tt_q;
        ones_d     = ones_q;
        err_d      = err_q;
        out_node_d = out_node_q;
        out_inv_d  = out_inv_q;
        // Table is frozen for the whole sweep so one result sees one network.
        if (cfg_we && state_q != ST_SWEEP) tbl_d[cfg_addr] = cfg_data;
        if (start_acc) begin
            cnt_d      = '0;
            tt_d       = '0;
            ones_d     = '0;
            err_d      = 1'b0;
            out_node_d = out_node;
            out_inv_d  = out_inv;
        end else if (state_q == ST_SWEEP) begin
            tt_d[cnt_q] = f_bit;
            ones_d      = ones_q + (NUM_IN+1)'(f_bit);
            err_d       = err_q | illegal;
            cnt_d       = cnt_q + NUM_IN'(1);   // wraps to 0 after last minterm
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q      <= '0;
            cnt_q      <= '0;
            tt_q       <= '0;
            ones_q     <= '0;
            err_q      <= 1'b0;
            out_node_q <= '0;
            out_inv_q  <= 1'b0;
        end else begin
            tbl_q      <= tbl_d;
            cnt_q      <= cnt_d;
            tt_q       <= tt_d;
            ones_q     <= ones_d;
            err_q      <= err_d;
            out_node_q <= out_node_d;
            out_inv_q  <= out_inv_d;
        end
    end

    assign tt       = tt_q;
    assign ones_cnt = ones_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_maj_tt_sweeper.sv
module tb_maj_tt_sweeper;

    localparam int NN = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [14:0]   cfg_data;
    logic [2:0]    out_node;
    logic          out_inv;
    logic          start;
    logic          busy;
    logic          cfg_err;
    logic          res_valid;
    logic          res_ready;
    logic [127:0]  tt;
    logic [7:0]    ones_cnt;

    int checks   = 0;
    int failures = 0;

    typedef logic [NN-1:0][14:0] tbl_t;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   ones;
        logic         err;
    } exp_t;

    typedef struct {
        string      name;
        tbl_t       tbl;
        logic [2:0] onode;
        logic       oinv;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    maj_tt_sweeper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_node  (out_node),
        .out_inv   (out_inv),
        .start     (start),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .tt        (tt),
        .ones_cnt  (ones_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] xin(input int i);
        return {1'b0, 4'(i + 1)};
    endfunction

    function automatic logic [4:0] nd(input int k);
        return {1'b0, 4'(8 + k)};
    endfunction

    function automatic logic [14:0] mw(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c);
        return {c, b, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_table(input tbl_t t);
        for (int k = 0; k < NN; k++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = 3'(k);
            cfg_data = t[k];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk({name, ".idle_valid"}, 128'(res_valid), 128'd0);
    endtask

    // Start a sweep, push expectation, wait for result, pop and compare.
    task automatic run(input string name, input logic [2:0] on, input logic oi,
                       input exp_t e, input bit poke, input bit hs);
        exp_t got;
        int   cyc;
        @(negedge clk);
        out_node = on;
        out_inv  = oi;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        // change select inputs: the DUT must use the values latched at start
        out_node = on + 3'd1;
        out_inv  = ~oi;
        cyc = 0;
        while (!res_valid && cyc < 400) begin
            if (poke && cyc == 10) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'd0;
                cfg_data = 15'd0;
            end else begin
                cfg_we = 1'b0;
            end
            if (cyc == 5) chk({name, ".busy"}, 128'(busy), 128'd1);
            @(posedge clk);
            #1;
            cyc++;
        end
        cfg_we = 1'b0;
        chk({name, ".latency"}, 128'(cyc), 128'd128);
        got = sb.pop_front();
        chk({name, ".tt"}, tt, got.tt);
        chk({name, ".ones"}, 128'(ones_cnt), 128'(got.ones));
        chk({name, ".cfg_err"}, 128'(cfg_err), 128'(got.err));
        if (hs) handshake(name);
    endtask

    initial begin
        tbl_t t_zero, t_maj3, t_big, t_fwd;
        exp_t e_zero, e_e8;
        logic [127:0] tt_hold;
        logic [7:0]   ones_hold;

        t_zero = '0;
        t_maj3 = '0;
        t_maj3[0] = mw(xin(0), xin(1), xin(2));
        t_big  = '0;
        t_big[0] = mw(xin(0), xin(3), xin(6));
        t_big[1] = mw(xin(2), xin(5), nd(0));
        t_big[2] = mw(xin(0), xin(1), nd(1));
        t_big[3] = mw(xin(0), xin(2), xin(3));
        t_big[4] = mw(xin(5), xin(6), nd(3));
        t_big[5] = mw(xin(1), nd(3), nd(4));
        t_big[6] = mw(xin(4), nd(2), nd(5));
        t_fwd    = t_big;
        // operand a refers forward to node5 -> reads 0, so node2 = x0 & x1
        t_fwd[2] = mw(nd(5), xin(0), xin(1));

        e_zero = '{tt: 128'd0, ones: 8'd0, err: 1'b0};
        e_e8   = '{tt: {16{8'he8}}, ones: 8'd64, err: 1'b0};

        vecs[0] = '{"zero",     t_zero, 3'd0, 1'b0, e_zero};
        vecs[1] = '{"zero_inv", t_zero, 3'd0, 1'b1, '{tt: {128{1'b1}}, ones: 8'd128, err: 1'b0}};
        vecs[2] = '{"maj3",     t_maj3, 3'd0, 1'b0, e_e8};
        vecs[3] = '{"net7",     t_big,  3'd6, 1'b0,
                    '{tt: 128'hfeeeeee8faa8e8a0fae8eaa0e8888880, ones: 8'd64, err: 1'b0}};
        vecs[4] = '{"fwd",      t_fwd,  3'd2, 1'b0, '{tt: {32{4'h8}}, ones: 8'd32, err: 1'b1}};
        vecs[5] = '{"err_clr",  t_maj3, 3'd0, 1'b0, e_e8};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        out_node = '0; out_inv = 1'b0; start = 1'b0; res_ready = 1'b0;
        #12;
        chk("rst.busy",      128'(busy),      128'd0);
        chk("rst.res_valid", 128'(res_valid), 128'd0);
        chk("rst.tt",        tt,              128'd0);
        chk("rst.ones",      128'(ones_cnt),  128'd0);
        chk("rst.cfg_err",   128'(cfg_err),   128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            load_table(vecs[v].tbl);
            run(vecs[v].name, vecs[v].onode, vecs[v].oinv, vecs[v].e, 1'b0, 1'b1);
        end

        // cfg_we during SWEEP is dropped: node0 stays MAJ(x0,x1,x2)
        load_table(t_maj3);
        run("sweep_cfg", 3'd0, 1'b0, e_e8, 1'b1, 1'b1);

        // Hold in DONE; start is ignored, cfg_we in DONE does write
        run("hold", 3'd0, 1'b0, e_e8, 1'b0, 1'b0);
        tt_hold   = tt;
        ones_hold = ones_cnt;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start    = (c == 5);
            cfg_we   = (c == 5);
            cfg_addr = 3'd0;
            cfg_data = 15'd0;
        end
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        chk("hold.tt",    tt,                tt_hold);
        chk("hold.ones",  128'(ones_cnt),    128'(ones_hold));
        chk("hold.valid", 128'(res_valid),   128'd1);
        chk("hold.busy",  128'(busy),        128'd0);
        // start together with handshake: handshake wins, no new sweep
        @(negedge clk);
        start = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; res_ready = 1'b0;
        chk("hs_start.valid", 128'(res_valid), 128'd0);
        @(posedge clk);
        #1;
        chk("hs_start.busy",  128'(busy),      128'd0);
        // node0 was overwritten with constant 0 while in DONE
        run("done_write", 3'd0, 1'b0, e_zero, 1'b0, 1'b1);

        // Reset in the middle of a sweep with cfg_err already set
        load_table(t_fwd);
        @(negedge clk);
        out_node = 3'd2; out_inv = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        chk("mid.busy_pre",  128'(busy),    128'd1);
        chk("mid.err_pre",   128'(cfg_err), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.busy",      128'(busy),      128'd0);
        chk("mid.res_valid", 128'(res_valid), 128'd0);
        chk("mid.tt",        tt,              128'd0);
        chk("mid.ones",      128'(ones_cnt),  128'd0);
        chk("mid.cfg_err",   128'(cfg_err),   128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // table cleared by reset: node2 is constant 0 again, no illegal refs
        run("post_rst", 3'd2, 1'b0, e_zero, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
